fnd_scan_ctrl: RTL and testbench

FND_SCAN_CTRL -- requirements
Module: fnd_scan_ctrl

---
 rtl/fnd_scan_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_fnd_scan_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fnd_scan_ctrl.sv
// rtl/fnd_scan_ctrl.sv - multiplexed 7-segment scan controller with sequential binary-to-BCD conversion
// Optional build macro: FND_LEADING_ZERO_BLANK_EN (blank leading zero digits)
module fnd_scan_ctrl #(
    parameter int DIGITS    = 4,
    parameter int DATA_W    = 14,
    parameter int SCAN_DIV  = 100_000,
    parameter int BLANK_CYC = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    input  logic [DIGITS-1:0] dp_in,
    output logic              busy,
    output logic [DIGITS-1:0] fnd_com,
    output logic [7:0]        fnd_data
);
    // One spare BCD digit beyond what DATA_W can ever need, so the shift never loses a bit.
    localparam int NB = (DATA_W + 2) / 3;
    localparam int ND = ((NB > DIGITS) ? NB : DIGITS) + 1;
    localparam int CW = $clog2(DATA_W + 1);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(DIGITS);

    typedef enum logic {BLANK, DRIVE} scan_state_t;

    logic [DATA_W-1:0]   conv_sh, sh_next, pend_d;
    logic [ND*4-1:0]     conv_bcd, bcd_adj, bcd_next;
    logic [CW-1:0]       conv_cnt;
    logic                busy_r, pend_v, conv_end, ovf;
    logic [DIGITS*4-1:0] disp;
    logic                disp_ovf;

    scan_state_t         state, state_nx;
    logic [SW-1:0]       cnt, cnt_nx;
    logic [IW-1:0]       idx, idx_nx;
    logic [3:0]          digit;
    logic [7:0]          seg;

    always_comb begin
        bcd_adj = conv_bcd;
        for (int i = 0; i < ND; i++) begin
            if (conv_bcd[i*4 +: 4] >= 4'd5)
                bcd_adj[i*4 +: 4] = conv_bcd[i*4 +: 4] + 4'd3;
        end
        {bcd_next, sh_next} = {bcd_adj[ND*4-2:0], conv_sh, 1'b0};
    end

    // Adding 3 never turns a zero digit nonzero or vice versa, so the adjusted view is equivalent here.
    assign ovf      = |bcd_adj[ND*4-1:DIGITS*4];
    assign conv_end = busy_r && (conv_cnt == CW'(DATA_W));
    assign busy     = busy_r;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            conv_sh  <= '0;
            conv_bcd <= '0;
            conv_cnt <= '0;
            busy_r   <= 1'b0;
            pend_v   <= 1'b0;
            pend_d   <= '0;
            disp     <= '0;
            disp_ovf <= 1'b0;
        end else if (!busy_r) begin
            if (data_valid) begin
                conv_sh  <= data_in;
                conv_bcd <= '0;
                conv_cnt <= '0;
                busy_r   <= 1'b1;
            end
        end else if (conv_end) begin
            disp     <= conv_bcd[DIGITS*4-1:0];
            disp_ovf <= ovf;
            if (pend_v) begin
                conv_sh  <= pend_d;
                conv_bcd <= '0;
                conv_cnt <= '0;
                pend_v   <= data_valid;
                pend_d   <= data_in;
            end else if (data_valid) begin
                conv_sh  <= data_in;
                conv_bcd <= '0;
                conv_cnt <= '0;
            end else begin
                busy_r   <= 1'b0;
            end
        end else begin
            conv_sh  <= sh_next;
            conv_bcd <= bcd_next;
            conv_cnt <= conv_cnt + 1'b1;
            if (data_valid) begin
                pend_v <= 1'b1;
                pend_d <= data_in;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= BLANK;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        idx_nx   = idx;
        case (state)
            BLANK: if (cnt == SW'(BLANK_CYC - 1)) begin
                state_nx = DRIVE;
                cnt_nx   = '0;
            end
            DRIVE: if (cnt == SW'(SCAN_DIV - BLANK_CYC - 1)) begin
                state_nx = BLANK;
                cnt_nx   = '0;
                idx_nx   = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end
            default: state_nx = BLANK;
        endcase
    end

    always_comb begin
        digit = disp[idx*4 +: 4];
        case (digit)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = 8'hFF;
        endcase
        if (disp_ovf)
            seg = 8'hBF;
`ifdef FND_LEADING_ZERO_BLANK_EN
        // Blank when this digit and everything above it is zero; digit 0 always shows.
        if (!disp_ovf && (idx != '0)) begin
            seg = 8'hFF;
            for (int j = 0; j < DIGITS; j++) begin
                if ((j >= int'(idx)) && (disp[j*4 +: 4] != 4'd0))
                    seg = (digit == 4'd0) ? 8'hC0 : seg;
            end
            if (seg == 8'hC0 || digit != 4'd0) begin
                case (digit)
                    4'd0:    seg = 8'hC0;
                    4'd1:    seg = 8'hF9;
                    4'd2:    seg = 8'hA4;
                    4'd3:    seg = 8'hB0;
                    4'd4:    seg = 8'h99;
                    4'd5:    seg = 8'h92;
                    4'd6:    seg = 8'h82;
                    4'd7:    seg = 8'hF8;
                    4'd8:    seg = 8'h80;
                    4'd9:    seg = 8'h90;
                    default: seg = 8'hFF;
                endcase
            end
        end
`endif
        seg[7] = ~dp_in[idx];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fnd_com  <= '1;
            fnd_data <= 8'hFF;
        end else if (state == DRIVE) begin
            fnd_com  <= ~(DIGITS'(1) << idx);
            fnd_data <= seg;
        end else begin
            fnd_com  <= '1;
            fnd_data <= 8'hFF;
        end
    end
endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// tb/tb_fnd_scan_ctrl.sv - self-checking bench for fnd_scan_ctrl against a value-level reference model
module tb_fnd_scan_ctrl;
    localparam int DIGITS    = 4;
    localparam int DATA_W    = 14;
    localparam int SCAN_DIV  = 8;
    localparam int BLANK_CYC = 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic [DATA_W-1:0] data_in = '0;
    logic              data_valid = 1'b0;
    logic [DIGITS-1:0] dp_in = '0;
    logic              busy;
    logic [DIGITS-1:0] fnd_com;
    logic [7:0]        fnd_data;

    int checks = 0;
    int errors = 0;

    // Reference model: scan time since reset release, displayed value, conversion queue.
    int t, disp, cur, rem, pend;
    bit m_busy, pv;

    always #5 clk = ~clk;

    fnd_scan_ctrl #(
        .DIGITS(DIGITS), .DATA_W(DATA_W), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_valid(data_valid),
        .dp_in(dp_in), .busy(busy), .fnd_com(fnd_com), .fnd_data(fnd_data)
    );

    function automatic logic [7:0] seg_of(int d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic cycle();
        logic [DIGITS-1:0] e_com;
        logic [7:0]        e_data;
        int pos, slot, p10, lim;
        pos  = t % SCAN_DIV;
        slot = (t / SCAN_DIV) % DIGITS;
        lim  = 10 ** DIGITS - 1;
        if (pos < BLANK_CYC) begin
            e_com  = '1;
            e_data = 8'hFF;
        end else begin
            e_com  = ~(DIGITS'(1) << slot);
            p10    = 10 ** slot;
            e_data = (disp > lim) ? 8'hBF : seg_of((disp / p10) % 10);
`ifdef FND_LEADING_ZERO_BLANK_EN
            if (disp <= lim && slot > 0 && disp < p10) e_data = 8'hFF;
`endif
            e_data[7] = ~dp_in[slot];
        end
        if (m_busy) begin
            rem--;
            if (rem == 0) begin
                disp = cur;
                if (pv) begin
                    cur = pend; rem = DATA_W + 1; pv = 0;
                    if (data_valid) begin pend = int'(data_in); pv = 1; end
                end else if (data_valid) begin
                    cur = int'(data_in); rem = DATA_W + 1;
                end else begin
                    m_busy = 0;
                end
            end else if (data_valid) begin
                pend = int'(data_in); pv = 1;
            end
        end else if (data_valid) begin
            m_busy = 1; cur = int'(data_in); rem = DATA_W + 1;
        end
        t++;
        @(posedge clk);
        #1;
        check("fnd_com", 32'(fnd_com), 32'(e_com));
        check("fnd_data", 32'(fnd_data), 32'(e_data));
        check("busy", 32'(busy), 32'(m_busy));
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic strobe(int value);
        data_valid = 1'b1;
        data_in    = DATA_W'(value);
        cycle();
        data_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_com", 32'(fnd_com), 32'(4'b1111));
        check("rst_data", 32'(fnd_data), 32'h0000_00FF);
        check("rst_busy", 32'(busy), 32'h0);
        t = 0; disp = 0; cur = 0; rem = 0; pend = 0; m_busy = 0; pv = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int r, v;
        #2;
        do_reset();
        idle(40);

        strobe(1234);
        idle(60);

        strobe(9999);
        idle(4);
        strobe(42);
        idle(70);

        strobe(10000);
        idle(50);
        dp_in = 4'b0100;
        idle(40);
        dp_in = '0;

        strobe(5678);
        idle(5);
        #2;
        do_reset();
        idle(40);

        strobe(1);
        strobe(2);
        strobe(3);
        idle(70);

        strobe(500);
        idle(14);
        strobe(77);
        idle(60);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 49) == 0) dp_in = DIGITS'($urandom);
            if ($urandom_range(0, 11) == 0) begin
                r = $urandom_range(0, 3);
                case (r)
                    0: v = $urandom_range(0, 9);
                    1: v = $urandom_range(0, 999);
                    2: v = $urandom_range(0, 9999);
                    default: v = $urandom_range(0, (1 << DATA_W) - 1);
                endcase
                strobe(v);
            end else begin
                cycle();
            end
        end
        idle(80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
